first_nios2_system_pll_rst_seq: RTL and testbench
=================================================

// Module: first_nios2_system_pll_rst_seq
// PURPOSE
//  Sequences PLL reset/lock for first_nios2_system. Pulses pll_rst, waits for a
//  synchronised, stable lock, then releases sys_rst to downstream logic.
//  Retries bounded on lock timeout and re-sequences on loss of lock.
//  Runs on the free-running reference clock feeding the PLL.
// PARAMETERS
//  RST_PULSE_CYCLES     16      cycles pll_rst held high per attempt (>=1)
//  LOCK_TIMEOUT_CYCLES  100000  max cycles in WAIT_LOCK before retry (>=2)
//  LOCK_STABLE_CYCLES   1024    consecutive locked cycles required (>=1)
//  MAX_RETRIES          3       PLL reset retries after the first attempt
//  SYNC_STAGES          2       synchroniser depth for pll_locked (>=2)
// PORTS
//  refclk          in   1  reference clock, 50 MHz, free-running
//  rst             in   1  asynchronous, active-high reset
//  pll_locked      in   1  PLL locked, asynchronous to refclk
//  soft_reset_req  in   1  1-cycle pulse; restarts the sequence
//  pll_rst         out  1  reset to PLL, active-high
//  sys_rst         out  1  system reset, active-high, sync deassert
//  pll_ready       out  1  1 only in RUN
//  fault           out  1  retries exhausted, PLL parked in reset
//  lock_loss_count out  8  saturating count of lock losses seen in RUN
// BEHAVIOUR
//  Reset (rst=1, immediate): state=RESET_PLL, cnt=0, retries=0, sync flops=0;
//   pll_rst=1, sys_rst=1, pll_ready=0, fault=0, lock_loss_count=0.
//  All outputs are registered. They take the value of the new state on the edge
//   that enters it.
//  lock_s = pll_locked after SYNC_STAGES flops. All decisions use lock_s only.
//  cnt width = $clog2(max of the three cycle params)+1. cnt clears on every
//   state change.
//  RESET_PLL: pll_rst=1, sys_rst=1. Exits when cnt==RST_PULSE_CYCLES-1 -> WAIT_LOCK,
//   so pll_rst is high exactly RST_PULSE_CYCLES cycles.
//  WAIT_LOCK: pll_rst=0, sys_rst=1. lock_s=1 -> STABLE.
//   Else at cnt==LOCK_TIMEOUT_CYCLES-1: retries<MAX_RETRIES -> retries++, RESET_PLL;
//   otherwise -> FAULT.
//  STABLE: lock_s=0 -> WAIT_LOCK (timeout restarts, retries unchanged).
//   lock_s=1 and cnt==LOCK_STABLE_CYCLES-1 -> RUN, retries=0.
//  RUN: sys_rst=0, pll_ready=1. lock_s=0 -> RESET_PLL, lock_loss_count+1
//   (saturates at 255), and sys_rst=1 on that same edge.
//  FAULT: pll_rst=1, sys_rst=1, fault=1. Stays until soft_reset_req.
//  soft_reset_req=1 in any state -> RESET_PLL, retries=0, fault=0.
//   It has priority over every lock/timeout event in the same cycle.
//   It does not clear lock_loss_count.
//  rst asserted mid-sequence: immediate return to reset values; restart from
//   RESET_PLL after release.
//  Glitches on pll_locked shorter than 1 cycle may be missed. Only synchronised
//   levels count.
// TESTING (bench params: RST_PULSE=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2, SYNC=2)
//  1 Release rst; pll_locked=1 from cycle 6 -> pll_rst high 4 cycles.
//    sys_rst falls and pll_ready rises 10 edges after first edge sampling pll_locked=1.
//  2 In STABLE, drop pll_locked for 2 cycles at cnt=5 -> back to WAIT_LOCK, sys_rst
//    stays 1. A full 8-cycle stable window is then required before RUN.
//  3 pll_locked held 0 -> 3 pll_rst pulses of 4 cycles, each 20 cycles apart.
//    Then fault=1, pll_rst=1 held, pll_ready=0.
//  4 In RUN, drop pll_locked -> next edge sys_rst=1, lock_loss_count=1, 4-cycle
//    pll_rst pulse. On relock, RUN again and lock_loss_count stays 1.
//  5 In FAULT, pulse soft_reset_req -> fault=0, pll_rst pulse, full 3-attempt budget.
//    Repeat with soft_reset_req coincident with a lock_s rise -> RESET_PLL wins.
//  6 Assert rst mid-WAIT_LOCK -> all outputs at reset values with no clock edge.
//    Force 256 lock losses -> lock_loss_count stays 255.

Source files
------------

// File: rtl/first_nios2_system_pll_rst_seq_if.sv
// PLL reset sequencer bundle: lock/soft-reset inputs and the reset/status outputs.
interface first_nios2_system_pll_rst_seq_if;
  localparam int unsigned LLC_W = 8;

  logic             pll_locked;
  logic             soft_reset_req;
  logic             pll_rst;
  logic             sys_rst;
  logic             pll_ready;
  logic             fault;
  logic [LLC_W-1:0] lock_loss_count;

  // Sequencer side
  modport master (
    input  pll_locked, soft_reset_req,
    output pll_rst, sys_rst, pll_ready, fault, lock_loss_count
  );

  // PLL / system side
  modport slave (
    output pll_locked, soft_reset_req,
    input  pll_rst, sys_rst, pll_ready, fault, lock_loss_count
  );
endinterface

// File: rtl/first_nios2_system_pll_rst_seq.sv
// PLL reset/lock sequencer for first_nios2_system.
// Pulses pll_rst, waits for a synchronised stable lock, then releases sys_rst.
// Bounded retries on lock timeout; re-sequences on loss of lock while running.
module first_nios2_system_pll_rst_seq #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic                            refclk,
  input  logic                            rst,
  first_nios2_system_pll_rst_seq_if.master seq_if
);

  localparam int unsigned MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int unsigned RET_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam int unsigned LLC_W   = 8;

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RET_W-1:0]   retries_q, retries_d;
  logic [LLC_W-1:0]   llc_q, llc_d;
  logic               pll_rst_q, sys_rst_q, pll_ready_q, fault_q;

  // Synchronise the asynchronous lock indication into refclk
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], seq_if.pll_locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next-state, counter, retry and lock-loss bookkeeping
  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    llc_d     = llc_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == CNT_W'(RST_PULSE_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          if (retries_q < RET_W'(MAX_RETRIES)) begin
            retries_d = retries_q + RET_W'(1);
            state_d   = S_RESET_PLL;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d   = S_RUN;
          retries_d = '0;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_RESET_PLL;
          if (llc_q != '1) begin
            llc_d = llc_q + LLC_W'(1);
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_RESET_PLL;
      end
    endcase

    // Soft reset overrides any lock or timeout event in the same cycle
    if (seq_if.soft_reset_req) begin
      state_d   = S_RESET_PLL;
      retries_d = '0;
      llc_d     = llc_q;
    end

    // Counter restarts on any state change or soft restart; idle in RUN/FAULT
    if ((state_d != state_q) || seq_if.soft_reset_req) begin
      cnt_d = '0;
    end else if ((state_q == S_RUN) || (state_q == S_FAULT)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State register with outputs decoded from the state being entered
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retries_q   <= '0;
      llc_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      pll_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      llc_q       <= llc_d;
      pll_rst_q   <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
      sys_rst_q   <= (state_d != S_RUN);
      pll_ready_q <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign seq_if.pll_rst         = pll_rst_q;
  assign seq_if.sys_rst         = sys_rst_q;
  assign seq_if.pll_ready       = pll_ready_q;
  assign seq_if.fault           = fault_q;
  assign seq_if.lock_loss_count = llc_q;

endmodule

// File: tb/tb_first_nios2_system_pll_rst_seq.sv
// Directed bench for the PLL reset sequencer (RST_PULSE=4, TIMEOUT=20,
// STABLE=8, MAX_RETRIES=2, SYNC=2).
module tb_first_nios2_system_pll_rst_seq;

  logic refclk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  first_nios2_system_pll_rst_seq_if bus_if ();

  first_nios2_system_pll_rst_seq #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2),
    .SYNC_STAGES        (2)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .seq_if(bus_if.master)
  );

  // 50 MHz reference clock
  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step until pll_ready rises, bounded by a cycle budget
  task automatic wait_ready(input string tag, input int budget);
    int n;
    n = 0;
    while ((bus_if.pll_ready !== 1'b1) && (n < budget)) begin
      step(1);
      n++;
    end
    chk(tag, 32'(bus_if.pll_ready), 32'd1);
  endtask

  // With lock held low: three 4-cycle pulses 24 edges apart, then FAULT at 72.
  // Caller has already taken the edge that entered the first RESET_PLL.
  task automatic run_budget(input string tag);
    for (int c = 0; c < 76; c++) begin
      if (c != 0) step(1);
      chk({tag, "_pll_rst"}, 32'(bus_if.pll_rst), 32'((c >= 72) || ((c % 24) < 4)));
      chk({tag, "_fault"}, 32'(bus_if.fault), 32'(c >= 72));
      chk({tag, "_ready"}, 32'(bus_if.pll_ready), 32'd0);
    end
  endtask

  initial begin
    tests_run             = 0;
    tests_failed          = 0;
    rst                   = 1'b1;
    bus_if.pll_locked     = 1'b0;
    bus_if.soft_reset_req = 1'b0;

    // Reset values
    step(2);
    chk("rst_pll_rst", 32'(bus_if.pll_rst), 32'd1);
    chk("rst_sys_rst", 32'(bus_if.sys_rst), 32'd1);
    chk("rst_ready", 32'(bus_if.pll_ready), 32'd0);
    chk("rst_fault", 32'(bus_if.fault), 32'd0);
    chk("rst_llc", 32'(bus_if.lock_loss_count), 32'd0);
    rst = 1'b0;

    // 1: pll_rst high 4 cycles, then lock seen at edge 6 -> RUN at edge 16
    for (int e = 1; e <= 4; e++) begin
      step(1);
      chk("t1_pll_rst_pulse", 32'(bus_if.pll_rst), 32'(e < 4));
    end
    step(1);
    bus_if.pll_locked = 1'b1;
    step(10);
    chk("t1_sys_rst_e15", 32'(bus_if.sys_rst), 32'd1);
    chk("t1_ready_e15", 32'(bus_if.pll_ready), 32'd0);
    step(1);
    chk("t1_sys_rst_e16", 32'(bus_if.sys_rst), 32'd0);
    chk("t1_ready_e16", 32'(bus_if.pll_ready), 32'd1);
    chk("t1_pll_rst_e16", 32'(bus_if.pll_rst), 32'd0);

    // 4: lock loss in RUN -> RESET_PLL after sync delay, count 1, relock
    bus_if.pll_locked = 1'b0;
    step(2);
    chk("t4_still_run", 32'(bus_if.pll_ready), 32'd1);
    step(1);
    chk("t4_sys_rst", 32'(bus_if.sys_rst), 32'd1);
    chk("t4_pll_rst", 32'(bus_if.pll_rst), 32'd1);
    chk("t4_ready", 32'(bus_if.pll_ready), 32'd0);
    chk("t4_llc", 32'(bus_if.lock_loss_count), 32'd1);
    bus_if.pll_locked = 1'b1;
    step(3);
    chk("t4_pll_rst_held", 32'(bus_if.pll_rst), 32'd1);
    step(1);
    chk("t4_pll_rst_low", 32'(bus_if.pll_rst), 32'd0);
    step(8);
    chk("t4_not_yet_run", 32'(bus_if.pll_ready), 32'd0);
    step(1);
    chk("t4_run_again", 32'(bus_if.pll_ready), 32'd1);
    chk("t4_llc_kept", 32'(bus_if.lock_loss_count), 32'd1);

    // 2: soft restart, then lock_s drops while STABLE cnt=5 -> full window again
    bus_if.soft_reset_req = 1'b1;
    step(1);
    bus_if.soft_reset_req = 1'b0;
    chk("t2_soft_pll_rst", 32'(bus_if.pll_rst), 32'd1);
    chk("t2_soft_sys_rst", 32'(bus_if.sys_rst), 32'd1);
    chk("t2_soft_llc", 32'(bus_if.lock_loss_count), 32'd1);
    step(4);
    chk("t2_wait_pll_rst", 32'(bus_if.pll_rst), 32'd0);
    step(4);
    bus_if.pll_locked = 1'b0;
    step(2);
    bus_if.pll_locked = 1'b1;
    step(1);
    chk("t2_drop_sys_rst", 32'(bus_if.sys_rst), 32'd1);
    step(9);
    chk("t2_no_early_run", 32'(bus_if.pll_ready), 32'd0);
    chk("t2_sys_rst_held", 32'(bus_if.sys_rst), 32'd1);
    step(1);
    chk("t2_run", 32'(bus_if.pll_ready), 32'd1);

    // 3: lock lost and never returns -> retry budget exhausted, FAULT
    bus_if.pll_locked = 1'b0;
    step(3);
    chk("t3_llc", 32'(bus_if.lock_loss_count), 32'd2);
    run_budget("t3");

    // 5a: soft reset out of FAULT restores the full retry budget
    bus_if.soft_reset_req = 1'b1;
    step(1);
    bus_if.soft_reset_req = 1'b0;
    run_budget("t5a");

    // 5b: soft reset coincident with lock_s rise in WAIT_LOCK -> RESET_PLL wins
    bus_if.soft_reset_req = 1'b1;
    step(1);
    bus_if.soft_reset_req = 1'b0;
    chk("t5b_fault_clr", 32'(bus_if.fault), 32'd0);
    step(8);
    bus_if.pll_locked = 1'b1;
    step(2);
    bus_if.soft_reset_req = 1'b1;
    step(1);
    bus_if.soft_reset_req = 1'b0;
    chk("t5b_prio_pll_rst", 32'(bus_if.pll_rst), 32'd1);
    chk("t5b_prio_sys_rst", 32'(bus_if.sys_rst), 32'd1);
    step(3);
    chk("t5b_pulse_held", 32'(bus_if.pll_rst), 32'd1);
    step(1);
    chk("t5b_pulse_end", 32'(bus_if.pll_rst), 32'd0);
    step(8);
    chk("t5b_not_run", 32'(bus_if.pll_ready), 32'd0);
    step(1);
    chk("t5b_run", 32'(bus_if.pll_ready), 32'd1);
    chk("t5b_llc", 32'(bus_if.lock_loss_count), 32'd2);

    // 6a: rst asserted mid-WAIT_LOCK takes effect without a clock edge
    bus_if.pll_locked     = 1'b0;
    bus_if.soft_reset_req = 1'b1;
    step(1);
    bus_if.soft_reset_req = 1'b0;
    step(5);
    chk("t6_wait_pll_rst", 32'(bus_if.pll_rst), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_pll_rst", 32'(bus_if.pll_rst), 32'd1);
    chk("t6_async_sys_rst", 32'(bus_if.sys_rst), 32'd1);
    chk("t6_async_ready", 32'(bus_if.pll_ready), 32'd0);
    chk("t6_async_fault", 32'(bus_if.fault), 32'd0);
    chk("t6_async_llc", 32'(bus_if.lock_loss_count), 32'd0);
    step(2);
    bus_if.pll_locked = 1'b1;
    rst = 1'b0;

    // 6b: 256 lock losses saturate the counter at 255
    for (int i = 1; i <= 256; i++) begin
      wait_ready("t6_reach_run", 60);
      bus_if.pll_locked = 1'b0;
      step(3);
      if (i == 1)   chk("t6_llc_first", 32'(bus_if.lock_loss_count), 32'd1);
      if (i == 255) chk("t6_llc_255", 32'(bus_if.lock_loss_count), 32'd255);
      if (i == 256) chk("t6_llc_sat", 32'(bus_if.lock_loss_count), 32'd255);
      bus_if.pll_locked = 1'b1;
    end
    wait_ready("t6_final_run", 60);
    chk("t6_llc_final", 32'(bus_if.lock_loss_count), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
